// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and constants for the video RAM arbiter
package vram_pkg;

    // Who owns the RAM read data returning in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_CPU_RD,
        OWN_CPU_WR
    } owner_t;

    // Width of the saturating video-streak counter.
    localparam int STREAK_W = 8;

endpackage

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port video RAM arbiter between scanout fetch and CPU bus
//
// Ports:
//   clk_in, reset_n          clock, asynchronous active-low reset
//   vid_valid/vid_addr       video fetch request; vid_ready = granted this cycle
//   vid_rvalid/vid_rdata     video read data, one cycle after grant
//   cpu_valid/cpu_we/...     CPU request held until cpu_ready
//   cpu_ready/cpu_rdata      one-cycle completion pulse with read data
//   mem_*                    RAM port; mem_rdata returns the cycle after mem_en
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 16,
    parameter int MAX_VID_STREAK = 7
) (
    input  logic                    clk_in,
    input  logic                    reset_n,
    input  logic                    vid_valid,
    input  logic [ADDR_WIDTH-1:0]   vid_addr,
    output logic                    vid_ready,
    output logic                    vid_rvalid,
    output logic [DATA_WIDTH-1:0]   vid_rdata,
    input  logic                    cpu_valid,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
    output logic                    cpu_ready,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_VID_STREAK);

    owner_t              resp_owner;
    logic                cpu_busy;
    logic [STREAK_W-1:0] streak;

    logic cpu_eligible;
    logic vid_grant;
    logic cpu_grant;

    // Grant decision and RAM port drive. Grants are gated by reset_n so the
    // combinational outputs sit at their reset values while reset is held.
    always_comb begin
        cpu_eligible = cpu_valid && !cpu_busy;
        vid_grant    = reset_n && vid_valid && (!cpu_eligible || (streak < MAX_STREAK));
        cpu_grant    = reset_n && !vid_grant && cpu_eligible;

        vid_ready = vid_grant;
        mem_en    = vid_grant || cpu_grant;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (vid_grant) begin
            mem_addr = vid_addr;
        end else if (cpu_grant) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wmask = cpu_we ? cpu_wstrb : '0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            resp_owner <= OWN_NONE;
            cpu_busy   <= 1'b0;
            streak     <= '0;
        end else begin
            if (vid_grant) begin
                resp_owner <= OWN_VID;
            end else if (cpu_grant) begin
                resp_owner <= cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
            end else begin
                resp_owner <= OWN_NONE;
            end

            // Busy covers exactly the response cycle, when the completed
            // request is still being held and must not be granted again.
            cpu_busy <= cpu_grant;

            if (cpu_grant || !cpu_eligible) begin
                streak <= '0;
            end else if (vid_grant && (streak != '1)) begin
                streak <= streak + 1'b1;
            end
        end
    end

    assign vid_rvalid = (resp_owner == OWN_VID);
    assign cpu_ready  = (resp_owner == OWN_CPU_RD) || (resp_owner == OWN_CPU_WR);
    assign vid_rdata  = vid_rvalid ? mem_rdata : '0;
    assign cpu_rdata  = cpu_ready  ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

    localparam int AW  = 14;
    localparam int DW  = 16;
    localparam int MAX = 7;

    logic          clk_in = 1'b0;
    logic          reset_n;
    logic          vid_valid;
    logic [AW-1:0] vid_addr;
    logic          vid_ready;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic          cpu_valid;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [1:0]    cpu_wstrb;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_wmask;
    logic [DW-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_VID_STREAK(MAX)) dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .vid_valid(vid_valid), .vid_addr(vid_addr), .vid_ready(vid_ready),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [15:0] pat(input int a);
        return 16'(a * 3 + 'h1000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM environment: synchronous read-first RAM with byte mask
    logic [15:0] ram    [0:(1<<AW)-1];
    logic [15:0] shadow [0:(1<<AW)-1];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]    = pat(i);
            shadow[i] = pat(i);
        end
    end

    always @(posedge clk_in) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            if (mem_we) begin
                if (mem_wmask[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
                if (mem_wmask[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
            end
        end
    end

    // Reference model: a CPU request waits while video keeps priority, but
    // once video has taken MAX slots while the CPU was waiting, the CPU goes.
    // Each grant yields exactly one response next cycle with the memory
    // contents as they were at grant time.
    logic        e_vg, e_cg, e_pend;
    logic        m_vid_resp, m_cpu_resp, m_cpu_rd;
    logic [15:0] m_data;
    int          m_run;

    always @(negedge clk_in) begin
        if (!reset_n) begin
            e_pend = 1'b0;
            e_vg   = 1'b0;
            e_cg   = 1'b0;
        end else begin
            e_pend = cpu_valid && !m_cpu_resp;
            e_vg   = vid_valid && (!e_pend || m_run < MAX);
            e_cg   = !e_vg && e_pend;
        end
        chk("vid_ready", vid_ready, e_vg);
        chk("mem_en", mem_en, e_vg || e_cg);
        if (e_vg || e_cg) begin
            chk("mem_we", mem_we, e_cg && cpu_we);
            chk("mem_addr", mem_addr, e_vg ? vid_addr : cpu_addr);
        end
        if (e_cg && cpu_we) begin
            chk("mem_wdata", mem_wdata, cpu_wdata);
            chk("mem_wmask", mem_wmask, cpu_wstrb);
        end
        if (e_cg && !cpu_we) chk("mem_wmask_rd", mem_wmask, 0);
        chk("vid_rvalid", vid_rvalid, m_vid_resp);
        if (m_vid_resp) chk("vid_rdata", vid_rdata, m_data);
        chk("cpu_ready", cpu_ready, m_cpu_resp);
        if (m_cpu_resp && m_cpu_rd) chk("cpu_rdata", cpu_rdata, m_data);
        if (!reset_n) begin
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_vid_rdata", vid_rdata, 0);
            chk("rst_cpu_rdata", cpu_rdata, 0);
        end
    end

    always @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            m_vid_resp = 1'b0;
            m_cpu_resp = 1'b0;
            m_cpu_rd   = 1'b0;
            m_data     = '0;
            m_run      = 0;
        end else begin
            m_vid_resp = e_vg;
            m_cpu_resp = e_cg;
            m_cpu_rd   = e_cg && !cpu_we;
            m_data     = e_vg ? shadow[vid_addr] : shadow[cpu_addr];
            if (e_cg && cpu_we) begin
                if (cpu_wstrb[0]) shadow[cpu_addr][7:0]  = cpu_wdata[7:0];
                if (cpu_wstrb[1]) shadow[cpu_addr][15:8] = cpu_wdata[15:8];
            end
            if (e_cg || !e_pend) m_run = 0;
            else if (e_vg && m_run < 255) m_run = m_run + 1;
        end
    end

    // Directed CPU access: holds cpu_valid until cpu_ready (inclusive), then drops it.
    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [15:0] d,
                          input logic [1:0] s, output logic [15:0] rd, output int lat,
                          output int ens);
        bit done;
        done = 0;
        lat  = 0;
        ens  = 0;
        rd   = '0;
        @(posedge clk_in); #1;
        cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk_in);
            lat++;
            if (mem_en) ens++;
            if (cpu_ready) begin
                done = 1;
                rd   = cpu_rdata;
            end else begin
                @(posedge clk_in); #1;
            end
        end
        chk("cpu_op_completes", done, 1);
        @(posedge clk_in); #1;
        cpu_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] vd [0:15];
        int lat, ens, nready, nrv, cg, cr, vgb, nrdy;
        logic [15:0] crd;
        logic vat, got;

        reset_n = 1'b0;
        vid_valid = 1'b1; vid_addr = 14'h5;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h6;
        cpu_wdata = '0; cpu_wstrb = '0;
        repeat (3) @(negedge clk_in);
        chk("reset_vid_ready", vid_ready, 0);
        chk("reset_mem_en", mem_en, 0);
        chk("reset_cpu_ready", cpu_ready, 0);
        chk("reset_vid_rvalid", vid_rvalid, 0);
        @(posedge clk_in); #1;
        vid_valid = 1'b0; cpu_valid = 1'b0;
        reset_n = 1'b1;

        // CPU only: write then read back
        cpu_op(1'b1, 14'h0010, 16'hBEEF, 2'b11, rd, lat, ens);
        chk("wr_latency", lat, 2);
        chk("wr_single_grant", ens, 1);
        cpu_op(1'b0, 14'h0010, 16'h0, 2'b00, rd, lat, ens);
        chk("rd_latency", lat, 2);
        chk("rd_data", rd, 16'hBEEF);
        chk("rd_single_grant", ens, 1);

        // Byte strobe
        cpu_op(1'b1, 14'h0030, 16'h1234, 2'b11, rd, lat, ens);
        cpu_op(1'b1, 14'h0030, 16'hABCD, 2'b01, rd, lat, ens);
        cpu_op(1'b0, 14'h0030, 16'h0, 2'b00, rd, lat, ens);
        chk("strobe_data", rd, 16'h12CD);

        // Video only, addresses 0..15
        nready = 0; nrv = 0;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk_in); #1;
            vid_valid = (i < 16);
            vid_addr  = 14'(i);
            @(negedge clk_in);
            if (vid_ready) nready++;
            if (vid_rvalid && nrv < 16) begin
                vd[nrv] = vid_rdata;
                nrv++;
            end
        end
        chk("vid_ready_count", nready, 16);
        chk("vid_rvalid_count", nrv, 16);
        for (int i = 0; i < 16; i++) chk("vid_stream_data", vd[i], pat(i));
        chk("vid_data_5", vd[5], 16'h100F);

        // Contention: both held from cycle 0
        cg = -1; cr = -1; vgb = 0; vat = 1'b0; crd = '0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_in); #1;
            if (c == 0) begin
                cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0020;
                vid_valid = 1'b1;
            end
            vid_addr = 14'(16'h100 + c);
            if (cr >= 0) cpu_valid = 1'b0;
            @(negedge clk_in);
            if (mem_en && !vid_ready && cg < 0) cg = c;
            if (vid_ready && cg < 0) vgb++;
            if (cpu_ready && cr < 0) begin
                cr = c; crd = cpu_rdata; vat = vid_ready;
            end
        end
        @(posedge clk_in); #1;
        vid_valid = 1'b0; cpu_valid = 1'b0;
        chk("cont_vid_before_cpu", vgb, 7);
        chk("cont_cpu_grant_cycle", cg, 7);
        chk("cont_cpu_ready_cycle", cr, 8);
        chk("cont_vid_resumes", vat, 1);
        chk("cont_cpu_data", crd, 16'h1060);

        // Reset in the cycle after a CPU grant
        @(posedge clk_in); #1;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010;
        @(negedge clk_in);
        chk("rst_flight_granted", mem_en, 1);
        @(posedge clk_in); #1;
        reset_n = 1'b0; cpu_valid = 1'b0;
        @(negedge clk_in);
        chk("rst_flight_cpu_ready", cpu_ready, 0);
        chk("rst_flight_mem_en", mem_en, 0);
        @(posedge clk_in); #1;
        reset_n = 1'b1;
        nrdy = 0;
        repeat (4) begin
            @(negedge clk_in);
            if (cpu_ready) nrdy++;
        end
        chk("rst_flight_no_ready", nrdy, 0);
        cpu_op(1'b0, 14'h0010, 16'h0, 2'b00, rd, lat, ens);
        chk("reissue_latency", lat, 2);
        chk("reissue_data", rd, 16'hBEEF);

        // Randomised traffic against the model
        got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_in); #1;
            vid_valid = ($urandom % 10) < 7;
            vid_addr  = 14'($urandom % 128);
            if (cpu_valid && got) cpu_valid = 1'b0;
            if (!cpu_valid && ($urandom % 10) < 5) begin
                cpu_valid = 1'b1;
                cpu_we    = 1'($urandom);
                cpu_addr  = 14'($urandom % 64);
                cpu_wdata = 16'($urandom);
                cpu_wstrb = 2'($urandom);
            end
            got = 1'b0;
            @(negedge clk_in);
            if (cpu_valid && cpu_ready) got = 1'b1;
        end
        @(posedge clk_in); #1;
        vid_valid = 1'b0; cpu_valid = 1'b0;
        repeat (2) @(negedge clk_in);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
